// File: rtl/io_uart_responder.sv
// io_uart_responder: 8N1 full-duplex UART peripheral on the j1 IO bus.
//   clk, resetq        : system clock, asynchronous active-low reset
//   io_rd, io_wr       : one-cycle read / write strobes from the CPU
//   io_addr, io_dout   : register address and write data
//   io_din             : read data, combinational on io_addr
//   interrupt_request  : registered level IRQ (irq_en & rx_valid)
//   uart_rx, uart_tx   : serial in (asynchronous, idle high) / serial out (idle high)
// Registers: DATA (TX FIFO push / RX byte read), STATUS
//   {11'b0, irq_en, overrun, tx_idle, rx_valid, tx_not_full}.
module io_uart_responder #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned TXDEPTH      = 4,
  parameter logic [15:0] ADDR_DATA    = 16'h1000,
  parameter logic [15:0] ADDR_STATUS  = 16'h2000
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        interrupt_request,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int unsigned AW = $clog2(TXDEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CntHalf = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  logic wr_data, wr_stat, rd_data;
  assign wr_data = io_wr & (io_addr == ADDR_DATA);
  assign wr_stat = io_wr & (io_addr == ADDR_STATUS);
  assign rd_data = io_rd & (io_addr == ADDR_DATA);

  // Only the low byte and the two control bits of the write data matter.
  logic unused_dout_hi;
  assign unused_dout_hi = ^io_dout[15:8];

  // ---------------- TX FIFO ----------------
  logic [7:0]  fifo_q [TXDEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        fifo_empty, fifo_full, tx_pop, fifo_push;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // A pop in the same cycle frees a slot, so a push on full is still accepted.
  assign fifo_push  = wr_data & (~fifo_full | tx_pop);

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_q[wptr_q[AW-1:0]] <= io_dout[7:0];
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (fifo_push) wptr_q <= wptr_q + 1'b1;
      if (tx_pop)    rptr_q <= rptr_q + 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = fifo_q[rptr_q[AW-1:0]];
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TxData;
        end
      end
      TxData: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TxStop;
          else                  tx_bit_d   = tx_bit_q + 1'b1;
        end
      end
      TxStop: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = fifo_q[rptr_q[AW-1:0]];
            tx_state_d = TxStart;
          end else begin
            tx_state_d = TxIdle;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    // Line level is registered from the next state so the pin never glitches.
    unique case (tx_state_d)
      TxStart: tx_d = 1'b0;
      TxData:  tx_d = tx_shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  assign uart_tx = tx_q;

  // ---------------- RX path ----------------
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d, overrun_q, overrun_d;
  logic          irq_en_q, irq_en_d, irq_q;
  logic          rx_done;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        // Falling edge only: a line stuck low never re-triggers.
        if (rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_cnt_q == CntHalf) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d   = '0;
          rx_state_d = RxIdle;
          rx_done    = rx_sync_q;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    irq_en_d   = irq_en_q;
    if (rd_data) rx_valid_d = 1'b0;
    if (wr_stat) begin
      irq_en_d = io_dout[4];
      if (io_dout[3]) overrun_d = 1'b0;
    end
    if (rx_done) begin
      // A read in the same cycle frees the holding register for the new byte.
      if (rx_valid_q && !rd_data) begin
        overrun_d = 1'b1;
      end else begin
        rx_byte_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_en_q & rx_valid_q;
    end
  end

  assign interrupt_request = irq_q;

  // ---------------- Read mux ----------------
  logic tx_idle;
  assign tx_idle = fifo_empty & (tx_state_q == TxIdle);

  always_comb begin
    io_din = 16'h0000;
    if (io_addr == ADDR_DATA) begin
      io_din = {8'h00, rx_byte_q};
    end else if (io_addr == ADDR_STATUS) begin
      io_din = {11'b0, irq_en_q, overrun_q, tx_idle, rx_valid_q, ~fifo_full};
    end
  end

endmodule

// File: tb/tb_io_uart_responder.sv
module tb_io_uart_responder;

  localparam int CPB   = 104;
  localparam int DEPTH = 4;
  localparam logic [15:0] AD = 16'h1000;
  localparam logic [15:0] AS = 16'h2000;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        io_rd = 1'b0, io_wr = 1'b0;
  logic [15:0] io_addr = 16'h0, io_dout = 16'h0;
  logic [15:0] io_din;
  logic        interrupt_request;
  logic        uart_rx = 1'b1;
  logic        uart_tx;

  io_uart_responder #(
    .CLKS_PER_BIT(CPB),
    .TXDEPTH     (DEPTH),
    .ADDR_DATA   (AD),
    .ADDR_STATUS (AS)
  ) dut (
    .clk              (clk),
    .resetq           (resetq),
    .io_rd            (io_rd),
    .io_wr            (io_wr),
    .io_addr          (io_addr),
    .io_dout          (io_dout),
    .io_din           (io_din),
    .interrupt_request(interrupt_request),
    .uart_rx          (uart_rx),
    .uart_tx          (uart_tx)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- Behavioural model ----------------
  // TX: a queue of pending bytes plus the current frame's position in clock
  // edges; the wire level follows from position / CPB.
  logic [7:0] q[$];
  bit         m_active = 0;
  int         m_pos = 0;
  logic [7:0] m_cur = 0;
  logic [7:0] m_rx_byte = 0;
  bit         m_rx_valid = 0, m_overrun = 0, m_irq_en = 0, m_irq = 0;
  int         rx_ev_cnt = 0, rx_seen = 0;
  logic [7:0] rx_ev_byte = 0;
  bit         rx_ev_ok = 0;
  bit         rx_busy = 0;
  int         cyc = 0;

  function automatic logic m_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  function automatic logic [15:0] m_status();
    return {11'b0, m_irq_en, m_overrun, (q.size() == 0) && !m_active, m_rx_valid,
            q.size() < DEPTH};
  endfunction

  task automatic model_step();
    bit wd, ws, rd;
    wd = io_wr && (io_addr == AD);
    ws = io_wr && (io_addr == AS);
    rd = io_rd && (io_addr == AD);
    m_irq = m_irq_en & m_rx_valid;
    if (m_active) m_pos++;
    if (!m_active || m_pos == 10 * CPB) begin
      if (q.size() > 0) begin
        m_cur    = q.pop_front();
        m_active = 1;
        m_pos    = 0;
      end else begin
        m_active = 0;
      end
    end
    if (wd && q.size() < DEPTH) q.push_back(io_dout[7:0]);
    if (rd) m_rx_valid = 0;
    if (ws) begin
      m_irq_en = io_dout[4];
      if (io_dout[3]) m_overrun = 0;
    end
    if (rx_seen != rx_ev_cnt) begin
      rx_seen = rx_ev_cnt;
      if (rx_ev_ok) begin
        if (m_rx_valid) m_overrun = 1;
        else begin
          m_rx_byte  = rx_ev_byte;
          m_rx_valid = 1;
        end
      end
    end
  endtask

  // Model update and per-cycle compare of uart_tx / interrupt_request.
  initial begin
    forever begin
      @(posedge clk or negedge resetq);
      if (!resetq) begin
        q.delete();
        m_active = 0; m_pos = 0; m_rx_byte = 0;
        m_rx_valid = 0; m_overrun = 0; m_irq_en = 0; m_irq = 0;
        rx_seen = rx_ev_cnt;
      end else begin
        cyc++;
        model_step();
      end
      #1;
      chk("uart_tx", 16'(uart_tx), 16'(m_tx()));
      if (!rx_busy) chk("irq", 16'(interrupt_request), 16'(m_irq));
    end
  end

  // ---------------- Bus / line drivers ----------------
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    io_wr = 1'b1; io_addr = a; io_dout = d;
    @(posedge clk);
    #2;
    io_wr = 1'b0; io_addr = 16'h0;
  endtask

  task automatic bus_read(input string nm, input logic [15:0] a, output logic [15:0] v);
    logic [15:0] e;
    @(negedge clk);
    io_rd = 1'b1; io_addr = a;
    #1;
    v = io_din;
    if (a == AD)      e = {8'h00, m_rx_byte};
    else if (a == AS) e = m_status();
    else              e = 16'h0000;
    chk(nm, v, e);
    @(posedge clk);
    #2;
    io_rd = 1'b0; io_addr = 16'h0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    rx_busy = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rx = fr[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rx    = 1'b1;
    rx_ev_byte = b;
    rx_ev_ok   = stop_ok;
    rx_ev_cnt++;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rx_busy = 0;
    repeat (4) @(negedge clk);
  endtask

  // Independent wire decoder for literal checks of the serial output.
  task automatic tx_decode(output logic [7:0] b, output int t0);
    int n;
    n = 0;
    b = 8'h00;
    while (uart_tx !== 1'b0 && n < 30 * CPB) begin
      @(negedge clk);
      n++;
    end
    chk("tx_start_seen", 16'(uart_tx), 16'h0);
    t0 = cyc;
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = uart_tx;
    end
    repeat (CPB) @(negedge clk);
    chk("tx_stop_bit", 16'(uart_tx), 16'h1);
  endtask

  task automatic watch_irq();
    bit seen;
    seen = 0;
    for (int i = 0; i < 11 * CPB && !seen; i++) begin
      @(negedge clk);
      if (io_din[1]) begin
        seen = 1;
        chk("irq_lag_low", 16'(interrupt_request), 16'h0);
        @(negedge clk);
        chk("irq_lag_high", 16'(interrupt_request), 16'h1);
      end
    end
    chk("rx_valid_seen", 16'(seen), 16'h1);
  endtask

  // ---------------- Stimulus ----------------
  logic [15:0] v;
  logic [7:0]  db [5];
  int          ts [5];
  logic [7:0]  eb;
  int          t0;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_tx", 16'(uart_tx), 16'h1);
    chk("reset_irq", 16'(interrupt_request), 16'h0);
    resetq = 1'b1;
    bus_read("status_reset", AS, v);
    chk("status_reset_lit", v, 16'h0005);
    bus_read("other_addr", 16'h3000, v);

    // Single byte 0x55.
    fork
      tx_decode(db[0], ts[0]);
      bus_write(AD, 16'h0155);
    join
    chk("tx_55", 16'(db[0]), 16'h0055);
    repeat (CPB) @(negedge clk);
    bus_read("status_after_55", AS, v);
    chk("status_after_55_lit", v, 16'h0005);

    // Burst into a busy line: 0x40 in the shifter, 41..44 queued, 45 dropped.
    fork
      for (int k = 0; k < 5; k++) tx_decode(db[k], ts[k]);
      begin
        bus_write(AD, 16'h0040);
        repeat (20) @(negedge clk);
        for (int k = 1; k <= 5; k++) bus_write(AD, 16'(8'h40 + k));
        bus_read("status_full", AS, v);
        chk("status_full_lit", v, 16'h0000);
      end
    join
    for (int k = 0; k < 5; k++) begin
      eb = 8'h40 + 8'(k);
      chk("burst_byte", 16'(db[k]), 16'(eb));
      if (k > 0) chk("burst_gap", 16'(ts[k] - ts[k-1]), 16'(10 * CPB));
    end
    repeat (CPB) @(negedge clk);
    bus_read("status_drained", AS, v);
    chk("status_drained_lit", v, 16'h0005);

    // Receive 0xA5 with IRQ enabled.
    bus_write(AS, 16'h0010);
    io_addr = AS;
    fork
      send_rx(8'hA5, 1'b1);
      watch_irq();
    join
    io_addr = 16'h0;
    bus_read("data_a5", AD, v);
    chk("data_a5_lit", v, 16'h00A5);
    repeat (2) @(negedge clk);
    chk("irq_cleared", 16'(interrupt_request), 16'h0);

    // Overrun.
    send_rx(8'h3C, 1'b1);
    send_rx(8'hC3, 1'b1);
    bus_read("status_overrun", AS, v);
    chk("status_overrun_lit", v, 16'h001F);
    bus_read("data_first_kept", AD, v);
    chk("data_first_kept_lit", v, 16'h003C);
    bus_write(AS, 16'h0018);
    bus_read("status_ovr_clr", AS, v);
    chk("status_ovr_clr_lit", v, 16'h0015);

    // Glitch and framing error.
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (20) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    bus_read("status_glitch", AS, v);
    chk("status_glitch_lit", v, 16'h0015);
    send_rx(8'h5A, 1'b0);
    bus_read("status_framing", AS, v);
    chk("status_framing_lit", v, 16'h0015);

    // Reset in the middle of a frame.
    bus_write(AD, 16'h00F0);
    repeat (300) @(negedge clk);
    #2;
    resetq = 1'b0;
    #1;
    chk("tx_high_in_reset", 16'(uart_tx), 16'h1);
    repeat (3) @(negedge clk);
    resetq = 1'b1;
    bus_read("status_after_rst", AS, v);
    chk("status_after_rst_lit", v, 16'h0005);

    // Randomized traffic, full duplex.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 8))
        0, 1, 2: repeat ($urandom_range(1, 3)) bus_write(AD, 16'($urandom));
        3:       send_rx(8'($urandom), 1'($urandom_range(0, 5) != 0));
        4:       bus_read("rnd_data", AD, v);
        5:       bus_read("rnd_status", AS, v);
        6:       bus_write(AS, 16'($urandom));
        7:       repeat ($urandom_range(1, 300)) @(negedge clk);
        default: bus_read("rnd_other", 16'($urandom), v);
      endcase
    end
    repeat (55 * CPB) @(negedge clk);
    bus_read("status_final", AS, v);
    chk("final_tx_idle", 16'(v[2]), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
